// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the data-memory port arbiter
//                and its round-robin sub-arbiter.
//                  owner_t  - read requester index (0 = fetch, 1 = load)
//                  tag_t    - requester tag carried with each read
//                  word_idx - word index of a byte address
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_NUM_RD = 2;
    localparam int c_TAG_W  = 4;
    localparam int c_DEPTH  = 1024;

    typedef logic [$clog2(c_NUM_RD)-1:0] owner_t;
    typedef logic [c_TAG_W-1:0]          tag_t;

    // Word index addr[$clog2(depth)-1:2], returned zero-extended. Written as
    // mask-and-shift so the helper works for any power-of-two depth.
    function automatic logic [c_ADDR_W-1:0] word_idx(
        input logic [c_ADDR_W-1:0] addr,
        input int unsigned         depth
    );
        return (addr & c_ADDR_W'(depth - 1)) >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin arbiter, purely combinational. Grants the
//                first requester at or after the pointer (mod N) and returns
//                the pointer value to use next cycle (one past the winner,
//                or unchanged when nothing is granted).
//  Ports       : i_req      - request vector
//                i_ptr      - current round-robin pointer
//                o_gnt      - one-hot grant
//                o_gnt_any  - any grant this cycle
//                o_gnt_idx  - index of the granted requester
//                o_ptr_nxt  - pointer for next cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_gnt_any,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic [IDX_W-1:0] o_ptr_nxt
);

    always_comb begin
        int idx;
        idx       = 0;
        o_gnt     = '0;
        o_gnt_any = 1'b0;
        o_gnt_idx = '0;
        o_ptr_nxt = i_ptr;
        // Scan from the farthest offset down to the pointer so the closest
        // requester at or after the pointer is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(i_ptr) + k) % N;
            if (i_req[idx]) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = IDX_W'(idx);
            end
        end
        if (o_gnt_any) begin
            o_gnt[o_gnt_idx] = 1'b1;
            o_ptr_nxt        = IDX_W'((int'(o_gnt_idx) + 1) % N);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a 1R/1W data memory (1-cycle read latency) between
//                read requesters (0 = fetch, 1 = load) and committed stores.
//                Stores always proceed; reads are round-robin arbitrated, a
//                read hitting the same word as a same-cycle store waits, and
//                load responses are dropped on flush.
//  Ports       : rd_req_*   - read requests (valid/addr/tag), ready = grant
//                rd_rsp_*   - one-hot response strobe, data, tag
//                st_*       - committed store, st_ready
//                flush      - kills load-side (index >= 1) reads
//                mem_rd_*   - memory read port, mem_rd_resp/data returned
//                mem_wr_*   - memory write port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int NUM_RD = 2,
    parameter int TAG_W  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0]              rd_req_valid,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_req_addr,
    input  logic [NUM_RD-1:0][TAG_W-1:0]   rd_req_tag,
    output logic [NUM_RD-1:0]              rd_req_ready,
    output logic [NUM_RD-1:0]              rd_rsp_valid,
    output logic [DATA_W-1:0]              rd_rsp_data,
    output logic [TAG_W-1:0]               rd_rsp_tag,
    input  logic                           st_valid,
    input  logic [ADDR_W-1:0]              st_addr,
    input  logic [DATA_W-1:0]              st_data,
    output logic                           st_ready,
    input  logic                           flush,
    output logic                           mem_rd_valid,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    input  logic                           mem_rd_resp,
    input  logic [DATA_W-1:0]              mem_rd_data,
    output logic                           mem_wr_valid,
    output logic [ADDR_W-1:0]              mem_wr_addr,
    output logic [DATA_W-1:0]              mem_wr_data
);

    logic [NUM_RD-1:0] w_elig;
    logic [NUM_RD-1:0] w_gnt;
    logic              w_gnt_any;
    owner_t            w_gnt_idx;
    owner_t            w_ptr_nxt;
    logic              w_rsp_kill;
    logic              w_rsp_fire;

    owner_t            r_rr_ptr;
    logic              r_inflight_v;
    owner_t            r_inflight_own;
    logic [TAG_W-1:0]  r_inflight_tag;
    logic              r_inflight_kill;

    // Stores are never blocked; the write port is a straight pass-through.
    assign st_ready     = ~rst;
    assign mem_wr_valid = st_valid & ~rst;
    assign mem_wr_addr  = st_addr;
    assign mem_wr_data  = st_data;

    // A read to the word being stored this cycle is held off one cycle so it
    // observes the new data. Under flush only the fetch requester competes.
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_elig
            logic w_conflict;
            assign w_conflict = st_valid &
                (word_idx(rd_req_addr[i], DEPTH) == word_idx(st_addr, DEPTH));
            assign w_elig[i]  = ~rst & rd_req_valid[i] & ~w_conflict &
                                ((i == 0) ? 1'b1 : ~flush);
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_RD)
    ) u_rr_arbiter (
        .i_req     (w_elig),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_any (w_gnt_any),
        .o_gnt_idx (w_gnt_idx),
        .o_ptr_nxt (w_ptr_nxt)
    );

    assign rd_req_ready = w_gnt;
    assign mem_rd_valid = w_gnt_any;
    assign mem_rd_addr  = w_gnt_any ? rd_req_addr[w_gnt_idx] : '0;

    // Load responses die if flush was seen at grant time or arrives now.
    assign w_rsp_kill = (r_inflight_own != '0) & (r_inflight_kill | flush);
    assign w_rsp_fire = ~rst & r_inflight_v & mem_rd_resp & ~w_rsp_kill;

    always_comb begin
        rd_rsp_valid = '0;
        if (w_rsp_fire) begin
            rd_rsp_valid[r_inflight_own] = 1'b1;
        end
    end

    assign rd_rsp_data = w_rsp_fire ? mem_rd_data    : '0;
    assign rd_rsp_tag  = w_rsp_fire ? r_inflight_tag : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr        <= '0;
            r_inflight_v    <= 1'b0;
            r_inflight_own  <= '0;
            r_inflight_tag  <= '0;
            r_inflight_kill <= 1'b0;
        end else begin
            r_rr_ptr     <= w_ptr_nxt;
            r_inflight_v <= w_gnt_any;
            if (w_gnt_any) begin
                r_inflight_own  <= w_gnt_idx;
                r_inflight_tag  <= rd_req_tag[w_gnt_idx];
                r_inflight_kill <= flush & (w_gnt_idx != '0);
            end
        end
    end

    // The memory must answer every issued read on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst && r_inflight_v) begin
            assert (mem_rd_resp);
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-read / single-write data memory (`mem`, 1-cycle read latency) between the core's read requesters and the committed-store drain. Instruction fetch and the load unit are read requesters. The block round-robin arbitrates reads and tracks the in-flight read so each response returns to its owner with its tag. It stalls a read that hits the same word as a simultaneous store, and it drops in-flight load responses on pipeline flush.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- DEPTH, 1024, memory depth in words; word index = addr[$clog2(DEPTH)-1:2]
- NUM_RD, 2, read requesters (0 = fetch, 1 = load)
- TAG_W, 4, requester tag width, returned unchanged with the response

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req_valid  in  NUM_RD  read request per requester
- rd_req_addr  in  NUM_RD×ADDR_W  byte address per requester
- rd_req_tag  in  NUM_RD×TAG_W  tag per requester
- rd_req_ready  out  NUM_RD  one-hot grant; a request transfers when valid & ready
- rd_rsp_valid  out  NUM_RD  one-hot response strobe; there is no backpressure
- rd_rsp_data  out  DATA_W  response data
- rd_rsp_tag  out  TAG_W  tag of the granted request
- st_valid, st_addr, st_data  in  1/ADDR_W/DATA_W  committed store
- st_ready  out  1  store accepted this cycle
- flush  in  1  kills in-flight and same-cycle load-requester (index ≥1) reads
- mem_rd_valid, mem_rd_addr  out  1/ADDR_W  to mem read port
- mem_rd_resp, mem_rd_data  in  1/DATA_W  from mem
- mem_wr_valid, mem_wr_addr, mem_wr_data  out  1/ADDR_W/DATA_W  to mem write port

## Operation
- Stores are never blocked. st_ready = ~rst. mem_wr_* = st_* while st_valid & ~rst.
- Read arbitration is round-robin, starting at pointer rr_ptr (reset 0).
  - Eligible requester: rd_req_valid[i] and no word-index match with a valid store this cycle.
  - Under flush, only index 0 is eligible.
  - The first eligible requester at or after rr_ptr (mod NUM_RD) is granted.
- On grant i:
  - rd_req_ready[i]=1, mem_rd_valid=1, mem_rd_addr = rd_req_addr[i].
  - Register inflight_v=1, inflight_own=i, inflight_tag.
  - rr_ptr ← (i+1) mod NUM_RD.
- With no grant, rr_ptr holds and inflight_v ← 0.
- Response: when mem_rd_resp & inflight_v, raise rd_rsp_valid[inflight_own], with rd_rsp_data = mem_rd_data and rd_rsp_tag = inflight_tag.
  - Exception: the response is suppressed when inflight_own ≥1 and flush was high in the grant cycle (registered inflight_kill) or is high in the response cycle.
- An inflight_v without mem_rd_resp is a protocol error. Flag it with an assertion only.
- Same-word read and store in the same cycle: the read is stalled one cycle, so it returns the stored data.
- A store issued the cycle after a read grant does not affect that read's data.

## Timing
- Grant is combinational in cycle t. The response is visible in cycle t+1. Throughput is one read per cycle plus one store per cycle.
- Reset values: rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_tag=0, st_ready=0, mem_rd_valid=0, mem_wr_valid=0, rr_ptr=0, inflight_v=0.
- Reset asserted mid-read: the pending response is discarded. No rd_rsp_valid appears in the cycle after reset deasserts.
- Requesters hold valid/addr/tag stable until granted. Fairness: any continuously-valid requester is granted within NUM_RD cycles, excluding store-conflict stalls.

## Structure
- Shared package mem_arb_pkg holds:
  - owner index type: logic [$clog2(NUM_RD)-1:0]
  - tag type
  - function word_idx(addr) returning addr[$clog2(DEPTH)-1:2]
- Sub-module rr_arbiter (N-way round-robin, request vector + pointer in, one-hot grant out, pointer update). It is reusable by the issue stage.

## Test plan
- Single load: requester 1 reads addr 0x0, tag 3; mem word 0 = 0x12345678 → ready[1] in cycle t, rsp_valid=2'b10, data 0x12345678, tag 3 in t+1.
- Both requesters valid continuously, addrs 0x4 and 0x8 → grants alternate 0,1,0,1 starting with 0 after reset. Each response is routed to the correct owner with its tag.
- Store 0xDEADBEEF to 0x10 and load 0x10 in the same cycle → load stalled one cycle. Its response returns 0xDEADBEEF. st_ready=1 in the first cycle.
- Flush in the cycle after a load grant → no rd_rsp_valid[1]. A fetch granted in the flush cycle still returns data.
- Store to 0x14 and load from 0x18 in the same cycle → both proceed in that cycle with no stall.
- Reset asserted the cycle after a grant → all outputs 0, no response delivered, rr_ptr=0 afterward.
